// File: rtl/bm_sched_pkg.sv
// Shared types and constants for the bm_rd_sched packet read scheduler.
// The optional checksum byte is enabled by defining BM_SCHED_CSUM_EN.
package bm_sched_pkg;

   localparam int unsigned SEQ_W       = 7;
   localparam int unsigned HDR_CH_BIT  = 7;
   localparam int unsigned HDR_SEQ_MSB = 6;

   typedef enum logic [2:0] {
      StIdle,
      StHdr,
      StRun,
      StDrain,
      StCsum,
      StDone
   } state_e;

   // Header byte: channel in the MSB, per-channel sequence number below it.
   function automatic logic [7:0] mk_hdr(input logic ch, input logic [SEQ_W-1:0] seq);
      logic [7:0] h;
      h                  = '0;
      h[HDR_CH_BIT]      = ch;
      h[HDR_SEQ_MSB:0]   = seq;
      return h;
   endfunction

endpackage

// File: rtl/bm_rr_arb.sv
// Two-way round-robin arbiter: when both channels are eligible the one that
// was not served last wins; a lone eligible channel always wins.
module bm_rr_arb (
   input  logic [1:0] i_elig,
   input  logic       i_rr_last,
   output logic       o_gnt,
   output logic       o_gnt_vld
);

   // Combinational grant; o_gnt is the winning channel index.
   always_comb begin
      o_gnt_vld = |i_elig;
      o_gnt     = 1'b0;
      if (&i_elig) begin
         o_gnt = ~i_rr_last;
      end else if (i_elig[1]) begin
         o_gnt = 1'b1;
      end
   end

endmodule

// File: rtl/bm_rd_sched.sv
// Packet read scheduler: shares one byte-wide packet output between two
// byte buffers. Emits a header, then streams PKT_LEN payload bytes read
// through an RD_LAT-deep tag pipe aligned to the buffer read latency.
// Define BM_SCHED_CSUM_EN to append an XOR checksum byte to every packet.
module bm_rd_sched
   import bm_sched_pkg::*;
#(
   parameter int unsigned PKT_LEN = 64,
   parameter int unsigned RD_LAT  = 2,
   parameter int unsigned LVL_W   = 16
) (
   input  logic             i_clk_sys,
   input  logic             i_rst,
   input  logic             i_en,
   input  logic [LVL_W-1:0] i_buf0_lvl,
   output logic             o_buf0_req,
   input  logic [7:0]       i_buf0_q,
   input  logic [LVL_W-1:0] i_buf1_lvl,
   output logic             o_buf1_req,
   input  logic [7:0]       i_buf1_q,
   output logic [7:0]       o_pk_data,
   output logic             o_pk_vld,
   output logic             o_pk_sop,
   output logic             o_pk_eop,
   output logic [15:0]      o_pk_cnt
);

   localparam logic [7:0] LAST_REQ = 8'(PKT_LEN - 1);

   state_e            r_state, w_state_nxt;
   logic              r_ch, r_rr_last;
   logic [SEQ_W-1:0]  r_seq0, r_seq1, w_seq;
   logic [7:0]        r_req_cnt;
   logic [RD_LAT-1:0] r_tag_vld, r_tag_last;
   logic              w_tag_out, w_tag_out_last;
   logic              w_run, w_push_last;
   logic [1:0]        w_elig;
   logic              w_gnt, w_gnt_vld;
   logic [7:0]        w_q, w_pk_data;
   logic              w_pk_vld, w_pk_sop, w_pk_eop;
   logic [7:0]        r_pk_data;
   logic              r_pk_vld, r_pk_sop, r_pk_eop;
   logic [15:0]       r_pk_cnt;
`ifdef BM_SCHED_CSUM_EN
   logic [7:0]        r_xor;
`endif

   assign w_elig = {i_buf1_lvl >= LVL_W'(PKT_LEN), i_buf0_lvl >= LVL_W'(PKT_LEN)};

   bm_rr_arb u_arb (
      .i_elig    (w_elig),
      .i_rr_last (r_rr_last),
      .o_gnt     (w_gnt),
      .o_gnt_vld (w_gnt_vld)
   );

   assign w_tag_out      = r_tag_vld[RD_LAT-1];
   assign w_tag_out_last = r_tag_last[RD_LAT-1];

   // State register.
   always_ff @(posedge i_clk_sys) begin
      if (i_rst) r_state <= StIdle;
      else       r_state <= w_state_nxt;
   end

   // Next-state logic; eligibility and enable only matter in StIdle.
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         StIdle:  if (i_en && w_gnt_vld) w_state_nxt = StHdr;
         StHdr:   w_state_nxt = StRun;
         StRun:   if (r_req_cnt == LAST_REQ) w_state_nxt = StDrain;
         StDrain: if (r_tag_vld == '0) begin
`ifdef BM_SCHED_CSUM_EN
            w_state_nxt = StCsum;
`else
            w_state_nxt = StDone;
`endif
         end
         StCsum:  w_state_nxt = StDone;
         StDone:  w_state_nxt = StIdle;
         default: w_state_nxt = StIdle;
      endcase
   end

   // Output decode: read requests and next packet-byte values.
   always_comb begin
      w_run       = (r_state == StRun);
      w_push_last = w_run && (r_req_cnt == LAST_REQ);
      w_q         = r_ch ? i_buf1_q : i_buf0_q;
      w_seq       = r_ch ? r_seq1 : r_seq0;
      w_pk_vld    = 1'b0;
      w_pk_sop    = 1'b0;
      w_pk_eop    = 1'b0;
      w_pk_data   = '0;
      if (r_state == StHdr) begin
         w_pk_vld  = 1'b1;
         w_pk_sop  = 1'b1;
         w_pk_data = mk_hdr(r_ch, w_seq);
      end else if (w_tag_out) begin
         w_pk_vld  = 1'b1;
         w_pk_data = w_q;
`ifdef BM_SCHED_CSUM_EN
         w_pk_eop  = 1'b0;
`else
         w_pk_eop  = w_tag_out_last;
`endif
      end
`ifdef BM_SCHED_CSUM_EN
      else if (r_state == StCsum) begin
         w_pk_vld  = 1'b1;
         w_pk_eop  = 1'b1;
         w_pk_data = r_xor;
      end
`endif
   end

   assign o_buf0_req = w_run & ~r_ch;
   assign o_buf1_req = w_run & r_ch;

   // Channel latch, request counter, tag pipe, sequence and packet counters.
   always_ff @(posedge i_clk_sys) begin
      if (i_rst) begin
         r_ch       <= 1'b0;
         r_rr_last  <= 1'b1;
         r_seq0     <= '0;
         r_seq1     <= '0;
         r_req_cnt  <= '0;
         r_tag_vld  <= '0;
         r_tag_last <= '0;
         r_pk_cnt   <= '0;
      end else begin
         // One tag per request; the tag reaches the output as the byte lands on q.
         r_tag_vld  <= (r_tag_vld << 1) | RD_LAT'(w_run);
         r_tag_last <= (r_tag_last << 1) | RD_LAT'(w_push_last);
         unique case (r_state)
            StIdle: if (i_en && w_gnt_vld) r_ch <= w_gnt;
            StHdr:  r_req_cnt <= '0;
            StRun:  r_req_cnt <= r_req_cnt + 8'd1;
            StDone: begin
               if (r_ch) r_seq1 <= r_seq1 + SEQ_W'(1);
               else      r_seq0 <= r_seq0 + SEQ_W'(1);
               r_pk_cnt  <= r_pk_cnt + 16'd1;
               r_rr_last <= r_ch;
            end
            default: ;
         endcase
      end
   end

`ifdef BM_SCHED_CSUM_EN
   // Running XOR of the payload bytes of the current packet.
   always_ff @(posedge i_clk_sys) begin
      if (i_rst || r_state == StHdr) r_xor <= '0;
      else if (w_tag_out)            r_xor <= r_xor ^ w_q;
   end
`endif

   // Single capture register stage for all packet outputs.
   always_ff @(posedge i_clk_sys) begin
      if (i_rst) begin
         r_pk_data <= '0;
         r_pk_vld  <= 1'b0;
         r_pk_sop  <= 1'b0;
         r_pk_eop  <= 1'b0;
      end else begin
         r_pk_data <= w_pk_data;
         r_pk_vld  <= w_pk_vld;
         r_pk_sop  <= w_pk_sop;
         r_pk_eop  <= w_pk_eop;
      end
   end

   assign o_pk_data = r_pk_data;
   assign o_pk_vld  = r_pk_vld;
   assign o_pk_sop  = r_pk_sop;
   assign o_pk_eop  = r_pk_eop;
   assign o_pk_cnt  = r_pk_cnt;

endmodule
